seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised successor to the 4-bit add/sub datapath ALU. Adds logic ops, set-less-than,
//  status flags and a multi-cycle shift-add multiplier. A valid/ready handshake sits in
//  front and behind the unit. It is the execute unit between the controller's operand
//  muxes and the register-file write-back.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      asynchronous, active-low reset (asserted when 0)
//  in_valid   in   1      operands/opcode valid
//  in_ready   out  1      unit can accept an operation
//  op         in   3      opcode (alu_pkg::alu_op_t)
//  a, b       in   WIDTH  operands
//  out_valid  out  1      result/flags valid; held until out_ready
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  result (MUL: low half)
//  result_hi  out  WIDTH  MUL high half; 0 for all other ops
//  flag_z/flag_n/flag_c/flag_v  out 1 each  zero, negative, carry, overflow
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE. in_ready=1 once released. out_valid=0.
//    result, result_hi and all flags = 0. Any in-flight MUL is aborted and discarded.
//  - States: IDLE -> (accept, op!=MUL) -> DONE; IDLE -> (accept, MUL) -> MUL;
//    MUL -> (iter count==WIDTH-1) -> DONE; DONE -> (out_ready) -> IDLE.
//  - in_ready = (state==IDLE). Accept = in_valid && in_ready. a, b and op are captured at accept.
//  - Latency from the accept edge T: non-MUL ops have out_valid=1 after edge T+1-1 (that is,
//    visible the next cycle). MUL has out_valid=1 after edge T+WIDTH.
//  - out_valid is 1 only in DONE. Outputs are held stable in DONE until out_ready.
//    No new accept can occur in the cycle out_ready is seen (throughput 1 op / 2 cycles minimum).
//  - Ops, with a/b unsigned and all arithmetic mod 2^WIDTH:
//    ADD=0  a+b; c=carry-out; v=signed overflow
//    SUB=1  a+~b+1; c=1 when no borrow (a>=b unsigned); v=signed overflow
//    AND=2 / OR=3 / XOR=4  bitwise; c=0, v=0
//    SLT=5  result = (signed a < signed b) ? 1 : 0; c=0, v=0
//    MUL=6  unsigned a*b, 2*WIDTH bits; {result_hi,result}=product; c=|result_hi; v=0
//    PASS=7 result=a; c=0, v=0
//  - z = (result==0), n = result[WIDTH-1], for all ops. MUL flags use the low half only.
//  - MUL: shift-add over WIDTH iterations using an accumulator of 2*WIDTH bits and a
//    log2(WIDTH)+1-bit counter. Each iteration tests the multiplier LSB and conditionally
//    adds the multiplicand into the upper half through the shared addsub. The upper half
//    keeps its carry, then the whole is shifted right 1. Counter wraps are not permitted;
//    exit is on count==WIDTH-1.
//  - Changes to a/b/op while not accepting have no effect.
// STRUCTURE
//  - alu_pkg: typedef enum logic [2:0] alu_op_t {ADD,SUB,AND,OR,XOR,SLT,MUL,PASS};
//    typedef enum logic [1:0] alu_state_t {IDLE,MUL,DONE}.
//  - Sub-module addsub #(WIDTH): a, b, sub -> sum, cout, ovf. This is the conditional-invert
//    adder, shared by ADD/SUB/SLT and the MUL accumulate step (sub=0).
//  - seq_alu: FSM, operand/accumulator registers, counter, output registers.
// TESTING (WIDTH=4 unless stated)
//  1. ADD a=7 b=9 -> one cycle later out_valid=1, result=0, z=1, c=1, v=0, n=0.
//  2. SUB a=3 b=5 -> result=14, n=1, c=0, v=0. SUB a=8 b=1 -> result=7, v=1, c=1.
//  3. MUL a=15 b=15 -> out_valid rises 4 cycles after accept. result=1, result_hi=14,
//     c=1, in_ready=0 throughout.
//  4. Backpressure: AND a=12 b=10 with out_ready=0 for 5 cycles -> result=8 held stable.
//     in_ready=0 for the whole hold. Accept again only after out_ready=1.
//  5. Reset mid-MUL (reset=0 at iteration 2) -> outputs 0 immediately and state IDLE.
//     After release, SLT a=14 b=1 -> result=1.
//  6. WIDTH=8 regression: MUL 200*3 -> {hi,lo}=0x0258 after 8 cycles. ADD 127+1 -> v=1, n=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode and FSM state encodings shared by the execute unit and its bench.
package alu_pkg;

   typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, SLT, MUL, PASS} alu_op_t;

   // State names carry a prefix so they do not collide with the MUL opcode.
   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} alu_state_t;

endpackage

// File: rtl/seq_alu_addsub.sv
// Conditional-invert adder: sum = a + (sub ? ~b + 1 : b), with carry-out and signed overflow.
module addsub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] w_b;
   logic [WIDTH:0]   w_full;

   assign w_b    = sub ? ~b : b;
   assign w_full = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};
   assign sum    = w_full[WIDTH-1:0];
   assign cout   = w_full[WIDTH];
   // Overflow: both addends share a sign that the sum does not.
   assign ovf    = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// Execute unit: single-cycle ADD/SUB/logic/SLT/PASS and a WIDTH-cycle shift-add MUL,
// with a valid/ready handshake on both sides and registered result/flags.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output alu_state_t       dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
   // Input side is ready only in IDLE; output side holds result/flags in DONE until out_ready.
   localparam int CW = $clog2(WIDTH) + 1;

   alu_state_t         r_state;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   r_result_hi;
   logic               r_z, r_n, r_c, r_v;

   alu_op_t            w_op;
   logic [WIDTH-1:0]   w_add_a, w_add_b, w_sum;
   logic               w_add_sub, w_cout, w_ovf;
   logic [WIDTH-1:0]   w_res;
   logic               w_c, w_v;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_op = alu_op_t'(op);

   // The adder sees the live operands in IDLE and the accumulator upper half during MUL.
   always_comb begin
      w_add_a   = a;
      w_add_b   = b;
      w_add_sub = (w_op == SUB) || (w_op == SLT);
      if (r_state == ST_MUL) begin
         w_add_a   = r_acc[2*WIDTH-1:WIDTH];
         w_add_b   = r_mcand;
         w_add_sub = 1'b0;
      end
   end

   addsub #(.WIDTH(WIDTH)) u_addsub (
      .a    (w_add_a),
      .b    (w_add_b),
      .sub  (w_add_sub),
      .sum  (w_sum),
      .cout (w_cout),
      .ovf  (w_ovf)
   );

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (w_op)
         ADD, SUB: begin
            w_res = w_sum;
            w_c   = w_cout;
            w_v   = w_ovf;
         end
         AND:     w_res = a & b;
         OR:      w_res = a | b;
         XOR:     w_res = a ^ b;
         SLT:     w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
         PASS:    w_res = a;
         default: w_res = '0;
      endcase
   end

   // Upper half keeps its carry, then the whole accumulator shifts right by one.
   assign w_acc_next = r_acc[0] ? {w_cout, w_sum, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_z         <= 1'b0;
         r_n         <= 1'b0;
         r_c         <= 1'b0;
         r_v         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (w_op == MUL) begin
                     r_acc   <= {{WIDTH{1'b0}}, b};
                     r_mcand <= a;
                     r_cnt   <= '0;
                     r_state <= ST_MUL;
                  end else begin
                     r_result    <= w_res;
                     r_result_hi <= '0;
                     r_z         <= (w_res == '0);
                     r_n         <= w_res[WIDTH-1];
                     r_c         <= w_c;
                     r_v         <= w_v;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH-1)) begin
                  r_result    <= w_acc_next[WIDTH-1:0];
                  r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                  r_z         <= (w_acc_next[WIDTH-1:0] == '0);
                  r_n         <= w_acc_next[WIDTH-1];
                  r_c         <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_v         <= 1'b0;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign flag_z    = r_z;
   assign flag_n    = r_n;
   assign flag_c    = r_c;
   assign flag_v    = r_v;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=4 and WIDTH=8.
module tb_seq_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Packed layout: {z,n,c,v, hi[7:0], lo[7:0]}
   logic [19:0] exp_q4[$];
   logic [19:0] exp_q8[$];

   logic       reset4, in_valid4, in_ready4, out_valid4, out_ready4;
   logic [2:0] op4;
   logic [3:0] a4, b4, res4, hi4;
   logic       z4, n4, c4, v4;
   alu_state_t st4;

   logic       reset8, in_valid8, in_ready8, out_valid8, out_ready8;
   logic [2:0] op8;
   logic [7:0] a8, b8, res8, hi8;
   logic       z8, n8, c8, v8;
   alu_state_t st8;

   seq_alu #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset4), .in_valid(in_valid4), .in_ready(in_ready4),
      .op(op4), .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
      .result(res4), .result_hi(hi4), .flag_z(z4), .flag_n(n4), .flag_c(c4),
      .flag_v(v4), .dbg_state(st4)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset8), .in_valid(in_valid8), .in_ready(in_ready8),
      .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .result(res8), .result_hi(hi8), .flag_z(z8), .flag_n(n8), .flag_c(c8),
      .flag_v(v8), .dbg_state(st8)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model written in plain integer arithmetic.
   function automatic logic [19:0] model(input int w, input logic [2:0] op,
                                         input logic [7:0] x, input logic [7:0] y);
      int mask, xi, yi, s, lo, hi, sx, sy;
      bit c, v;
      mask = (1 << w) - 1;
      xi = int'(x) & mask;
      yi = int'(y) & mask;
      lo = 0; hi = 0; c = 0; v = 0;
      case (op)
         3'd0: begin
            s = xi + yi; lo = s & mask; c = s[w];
            v = (xi[w-1] == yi[w-1]) && (lo[w-1] != xi[w-1]);
         end
         3'd1: begin
            s = xi + ((~yi) & mask) + 1; lo = s & mask; c = s[w];
            v = (xi[w-1] != yi[w-1]) && (lo[w-1] != xi[w-1]);
         end
         3'd2: lo = xi & yi;
         3'd3: lo = xi | yi;
         3'd4: lo = xi ^ yi;
         3'd5: begin
            sx = xi[w-1] ? xi - (1 << w) : xi;
            sy = yi[w-1] ? yi - (1 << w) : yi;
            lo = (sx < sy) ? 1 : 0;
         end
         3'd6: begin
            s = xi * yi; lo = s & mask; hi = (s >> w) & mask; c = (hi != 0);
         end
         default: lo = xi;
      endcase
      return {(lo == 0), lo[w-1], c, v, hi[7:0], lo[7:0]};
   endfunction

   function automatic logic [19:0] pack4();
      return {z4, n4, c4, v4, 4'h0, hi4, 4'h0, res4};
   endfunction

   function automatic logic [19:0] pack8();
      return {z8, n8, c8, v8, hi8, res8};
   endfunction

   task automatic run4(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                       input int hold);
      int lat, bad;
      logic [19:0] got, e, snap;
      @(negedge clk);
      check_eq("ready4", in_ready4, 1);
      op4 = op; a4 = x; b4 = y; in_valid4 = 1'b1;
      exp_q4.push_back(model(4, op, {4'h0, x}, {4'h0, y}));
      @(posedge clk); #1;
      // Garbage on the inputs while busy must not be taken.
      op4 = 3'($urandom_range(0, 7)); a4 = 4'($urandom); b4 = 4'($urandom);
      lat = 0; bad = 0;
      @(negedge clk);
      while (!out_valid4 && lat < 40) begin
         if (in_ready4) bad++;
         @(negedge clk);
         lat++;
      end
      check_eq("lat4", lat, (op == 3'd6) ? 4 : 0);
      check_eq("busy4", bad, 0);
      got = pack4();
      if (exp_q4.size() > 0) e = exp_q4.pop_front();
      else e = 'x;
      check_eq("res4", got, e);
      snap = got; bad = 0;
      repeat (hold) begin
         @(negedge clk);
         if (pack4() !== snap || in_ready4 || !out_valid4) bad++;
      end
      if (hold > 0) check_eq("hold4", bad, 0);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0; in_valid4 = 1'b0;
      check_eq("release4", {in_ready4, out_valid4}, 2'b10);
   endtask

   task automatic run8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
      int lat, bad;
      logic [19:0] e;
      @(negedge clk);
      op8 = op; a8 = x; b8 = y; in_valid8 = 1'b1;
      exp_q8.push_back(model(8, op, x, y));
      @(posedge clk); #1;
      op8 = 3'($urandom_range(0, 7)); a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0; bad = 0;
      @(negedge clk);
      while (!out_valid8 && lat < 40) begin
         if (in_ready8) bad++;
         @(negedge clk);
         lat++;
      end
      check_eq("lat8", lat, (op == 3'd6) ? 8 : 0);
      check_eq("busy8", bad, 0);
      if (exp_q8.size() > 0) e = exp_q8.pop_front();
      else e = 'x;
      check_eq("res8", pack8(), e);
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0; in_valid8 = 1'b0;
      check_eq("release8", {in_ready8, out_valid8}, 2'b10);
   endtask

   initial begin
      reset4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
      reset8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      #2;
      check_eq("rst_out4", {out_valid4, pack4()}, 21'h0);
      check_eq("rst_out8", {out_valid8, pack8()}, 21'h0);
      check_eq("rst_st4", 32'(st4), 32'(ST_IDLE));
      @(negedge clk);
      reset4 = 1'b1; reset8 = 1'b1;

      run4(3'd0, 4'd7, 4'd9, 0);
      run4(3'd1, 4'd3, 4'd5, 1);
      run4(3'd1, 4'd8, 4'd1, 0);
      run4(3'd6, 4'd15, 4'd15, 2);
      run4(3'd2, 4'd12, 4'd10, 5);

      // Abort a MUL after its second iteration.
      @(negedge clk);
      op4 = 3'd6; a4 = 4'd13; b4 = 4'd11; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset4 = 1'b0;
      #1;
      check_eq("abort_out", {out_valid4, pack4()}, 21'h0);
      check_eq("abort_st", 32'(st4), 32'(ST_IDLE));
      @(negedge clk);
      reset4 = 1'b1;
      run4(3'd5, 4'd14, 4'd1, 0);

      run4(3'd6, 4'd0, 4'd15, 0);
      run4(3'd5, 4'd7, 4'd8, 0);
      run4(3'd5, 4'd8, 4'd7, 0);
      run4(3'd7, 4'd9, 4'd3, 1);
      run4(3'd4, 4'd5, 4'd5, 0);
      for (int i = 0; i < 16; i++)
         run4(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), $urandom_range(0, 2));

      run8(3'd6, 8'd200, 8'd3);
      run8(3'd0, 8'd127, 8'd1);
      run8(3'd6, 8'd255, 8'd255);
      for (int i = 0; i < 10; i++)
         run8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));

      check_eq("q_left", exp_q4.size() + exp_q8.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
